// File: rtl/tri_link_pkg.sv
// Shared state encoding and line-level constants for the single-wire tristate link.
package tri_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        TURN,
        TX_START,
        TX_DATA,
        TX_STOP
    } linkState_t;

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/tri_link_bit_timer.sv
// Per-bit clock counter; wraps at the bit boundary and strobes mid-bit and end-of-bit.
module tri_link_bit_timer #(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic midBit,
    output logic endBit
);

    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] MID_COUNT  = CW'(BIT_CYCLES / 2);
    localparam logic [CW-1:0] LAST_COUNT = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || count == LAST_COUNT) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign midBit = (count == MID_COUNT);
    assign endBit = (count == LAST_COUNT);

endmodule

// File: rtl/tri_link_responder.sv
// Responder end of a half-duplex single-wire link: receives a host frame, waits
// a turnaround gap, then drives the held response frame back and releases the line.
module tri_link_responder
    import tri_link_pkg::*;
#(
    parameter int unsigned BIT_CYCLES  = 4,
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pad_i,
    output logic              pad_o,
    output logic              pad_oe,
    input  logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
);

    localparam int unsigned IW = $clog2(DATA_W + 1);
    localparam int unsigned TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_W - 1);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);

    linkState_t state, stateNext;

    logic              lineMeta, lineSync, linePrev;
    logic              fallEdge;
    logic              timerClear, midBit, endBit;
    logic [DATA_W-1:0] rxShift, rxDataQ, txShift, holdData;
    logic [IW-1:0]     bitIdx;
    logic [TW-1:0]     turnCnt;
    logic              stopOk, frameErr, rxValidQ;
    logic              holdFull, holdFullNext, rspReadyQ, rspAccept;

    tri_link_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bitTimer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timerClear),
        .midBit (midBit),
        .endBit (endBit)
    );

    // Idle line is pulled high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lineMeta <= 1'b1;
            lineSync <= 1'b1;
            linePrev <= 1'b1;
        end else begin
            lineMeta <= pad_i;
            lineSync <= lineMeta;
            linePrev <= lineSync;
        end
    end

    assign fallEdge  = linePrev & ~lineSync;
    assign rspAccept = rsp_valid & rspReadyQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        timerClear = 1'b0;
        pad_oe     = 1'b0;
        pad_o      = STOP_LEVEL;
        case (state)
            IDLE: begin
                // The edge cycle itself is count 0 of the start bit.
                timerClear = ~fallEdge;
                if (fallEdge) stateNext = RX_START;
            end
            RX_START: begin
                if (midBit) stateNext = (lineSync == START_LEVEL) ? RX_DATA : IDLE;
            end
            RX_DATA: begin
                if (midBit && bitIdx == LAST_IDX) stateNext = RX_STOP;
            end
            RX_STOP: begin
                if (stopOk && endBit) stateNext = TURN;
                else if (frameErr && lineSync == STOP_LEVEL) stateNext = IDLE;
            end
            TURN: begin
                timerClear = 1'b1;
                if (turnCnt == TURN_LAST) stateNext = (holdFull || rspAccept) ? TX_START : IDLE;
            end
            TX_START: begin
                pad_oe = 1'b1;
                pad_o  = START_LEVEL;
                if (endBit) stateNext = TX_DATA;
            end
            TX_DATA: begin
                pad_oe = 1'b1;
                pad_o  = txShift[0];
                if (endBit && bitIdx == LAST_IDX) stateNext = TX_STOP;
            end
            TX_STOP: begin
                pad_oe = 1'b1;
                pad_o  = STOP_LEVEL;
                if (endBit) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        holdFullNext = holdFull;
        if (rspAccept) holdFullNext = 1'b1;
        else if (state == TX_STOP && endBit) holdFullNext = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxShift   <= '0;
            rxDataQ   <= '0;
            rxValidQ  <= 1'b0;
            txShift   <= '0;
            holdData  <= '0;
            holdFull  <= 1'b0;
            rspReadyQ <= 1'b0;
            bitIdx    <= '0;
            turnCnt   <= '0;
            stopOk    <= 1'b0;
            frameErr  <= 1'b0;
        end else begin
            rxValidQ  <= 1'b0;
            holdFull  <= holdFullNext;
            rspReadyQ <= ~holdFullNext;
            if (rspAccept) holdData <= rsp_data;
            turnCnt <= (state == TURN && turnCnt != TURN_LAST) ? turnCnt + TW'(1) : '0;
            case (state)
                IDLE: begin
                    stopOk   <= 1'b0;
                    frameErr <= 1'b0;
                end
                RX_START: bitIdx <= '0;
                RX_DATA: begin
                    if (midBit) begin
                        rxShift <= {lineSync, rxShift[DATA_W-1:1]};
                        bitIdx  <= bitIdx + IW'(1);
                    end
                end
                RX_STOP: begin
                    if (midBit && !stopOk && !frameErr) begin
                        if (lineSync == STOP_LEVEL) begin
                            rxDataQ  <= rxShift;
                            rxValidQ <= 1'b1;
                            stopOk   <= 1'b1;
                        end else begin
                            frameErr <= 1'b1;
                        end
                    end
                end
                TX_START: begin
                    txShift <= holdData;
                    bitIdx  <= '0;
                end
                TX_DATA: begin
                    if (endBit) begin
                        txShift <= txShift >> 1;
                        bitIdx  <= bitIdx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_ready = rspReadyQ;
    assign rx_data   = rxDataQ;
    assign rx_valid  = rxValidQ;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_tri_link_responder.sv
// Self-checking bench: a host model drives frames on the shared line and a
// frame-level reference predicts received bytes and response waveforms.
module tb_tri_link_responder;

    localparam int BC    = 4;
    localparam int TURN  = 2;
    localparam int DW    = 8;
    localparam int FRAME = (DW + 2) * BC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          padI, pad_o, pad_oe;
    logic [DW-1:0] rsp_data;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid, busy;
    logic          hostOe = 1'b0;
    logic          hostVal = 1'b1;

    int            cyc = 0;
    int            nChecks = 0;
    int            nPass = 0;
    int            hostEnd = 0;
    int            overlaps = 0;
    logic [DW-1:0] lastRx = '0;
    logic          oePrev = 1'b0;

    logic [DW-1:0] rxQ[$];
    int            txStart[$];
    logic          txBits[$];

    // Resolved line: responder wins when enabled, else the host, else the pull-up.
    assign padI = pad_oe ? pad_o : (hostOe ? hostVal : 1'b1);

    tri_link_responder #(
        .BIT_CYCLES (BC),
        .TURN_CYCLES(TURN),
        .DATA_W     (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pad_i    (padI),
        .pad_o    (pad_o),
        .pad_oe   (pad_oe),
        .rsp_data (rsp_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) rxQ.push_back(rx_data);
        if (pad_oe) begin
            if (!oePrev) txStart.push_back(cyc);
            txBits.push_back(pad_o);
            if (hostOe) overlaps <= overlaps + 1;
        end
        oePrev <= pad_oe;
    end

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else nPass++;
    endtask

    // Line level expected at cycle i of a response frame carrying byte r.
    function automatic logic expTxBit(input logic [DW-1:0] r, input int i);
        int b;
        b = i / BC;
        if (b == 0) return 1'b0;
        if (b <= DW) return r[b-1];
        return 1'b1;
    endfunction

    task automatic hostFrame(input logic [DW-1:0] d, input logic stopBit);
        logic [DW+1:0] bits;
        bits = {stopBit, d, 1'b0};
        for (int b = 0; b < DW + 2; b++) begin
            for (int c = 0; c < BC; c++) begin
                @(posedge clk); #1;
                hostOe  = 1'b1;
                hostVal = bits[b];
            end
        end
        @(posedge clk); #1;
        hostOe  = 1'b0;
        hostVal = 1'b1;
        hostEnd = cyc;
    endtask

    task automatic loadRsp(input logic [DW-1:0] r);
        bit done;
        done = 1'b0;
        @(posedge clk); #1;
        rsp_valid = 1'b1;
        rsp_data  = r;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (rsp_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        rsp_valid = 1'b0;
        checkValue("rspAccept", {31'd0, done}, 1);
        @(negedge clk);
        checkValue("rspReadyLow", {31'd0, rsp_ready}, 0);
    endtask

    task automatic runExchange(input logic [DW-1:0] d, input bit withRsp, input logic [DW-1:0] r);
        int rxMark, txMark, stMark;
        logic obs;
        if (withRsp) loadRsp(r);
        rxMark = rxQ.size();
        txMark = txBits.size();
        stMark = txStart.size();
        hostFrame(d, 1'b1);
        repeat (2 + TURN + FRAME + 6) @(posedge clk);
        @(negedge clk);
        lastRx = d;
        checkValue("rxCount", rxQ.size() - rxMark, 1);
        checkValue("rxData", (rxQ.size() > rxMark) ? {24'd0, rxQ[rxMark]} : 32'hFFFF_FFFF, {24'd0, d});
        checkValue("rxDataReg", {24'd0, rx_data}, {24'd0, d});
        if (withRsp) begin
            checkValue("txLen", txBits.size() - txMark, FRAME);
            checkValue("txStart", (txStart.size() > stMark) ? txStart[stMark] : -1, hostEnd + 2 + TURN);
            for (int i = 0; i < FRAME; i++) begin
                obs = (txMark + i < txBits.size()) ? txBits[txMark + i] : 1'bx;
                checkValue($sformatf("txBit%0d", i), {31'd0, obs}, {31'd0, expTxBit(r, i)});
            end
        end else begin
            checkValue("txLenNone", txBits.size() - txMark, 0);
        end
        checkValue("busyAfter", {31'd0, busy}, 0);
        checkValue("rspReadyAfter", {31'd0, rsp_ready}, 1);
    endtask

    initial begin : stimulus
        int rxMark, txMark, target;
        logic [DW-1:0] d, r;
        rsp_valid = 1'b0;
        rsp_data  = '0;

        repeat (3) @(negedge clk);
        checkValue("rstPadO", {31'd0, pad_o}, 1);
        checkValue("rstPadOe", {31'd0, pad_oe}, 0);
        checkValue("rstRspReady", {31'd0, rsp_ready}, 0);
        checkValue("rstRxData", {24'd0, rx_data}, 0);
        checkValue("rstRxValid", {31'd0, rx_valid}, 0);
        checkValue("rstBusy", {31'd0, busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkValue("rspReadyIdle", {31'd0, rsp_ready}, 1);

        runExchange(8'hA5, 1'b0, 8'h00);
        runExchange(8'h01, 1'b1, 8'h3C);
        r = 8'($urandom);
        runExchange(8'h11, 1'b1, r);
        r = 8'($urandom);
        runExchange(8'h22, 1'b1, r);

        for (int it = 0; it < 6; it++) begin
            d = 8'($urandom);
            r = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            runExchange(d, 1'($urandom_range(0, 1)), r);
        end

        // Single-clock low glitch on an idle line.
        rxMark = rxQ.size();
        txMark = txBits.size();
        @(posedge clk); #1;
        hostOe = 1'b1; hostVal = 1'b0;
        @(posedge clk); #1;
        hostOe = 1'b0; hostVal = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkValue("glitchBusy", {31'd0, busy}, 1);
        repeat (BC + 6) @(posedge clk);
        @(negedge clk);
        checkValue("glitchIdle", {31'd0, busy}, 0);
        checkValue("glitchNoRx", rxQ.size() - rxMark, 0);
        checkValue("glitchNoTx", txBits.size() - txMark, 0);

        // Framing error with a response held: nothing received, nothing sent.
        loadRsp(8'($urandom));
        rxMark = rxQ.size();
        txMark = txBits.size();
        hostFrame(8'($urandom), 1'b0);
        repeat (2 + TURN + FRAME + 6) @(posedge clk);
        @(negedge clk);
        checkValue("ferrNoRx", rxQ.size() - rxMark, 0);
        checkValue("ferrRxKept", {24'd0, rx_data}, {24'd0, lastRx});
        checkValue("ferrNoTx", txBits.size() - txMark, 0);
        checkValue("ferrHeld", {31'd0, rsp_ready}, 0);
        checkValue("ferrIdle", {31'd0, busy}, 0);

        // Good frame uses the still-held response; reset lands 10 clocks into TX_DATA.
        rxMark = rxQ.size();
        hostFrame(8'h5A, 1'b1);
        target = hostEnd + 2 + TURN + BC + 10;
        while (cyc < target) begin
            @(posedge clk); #1;
        end
        checkValue("oeBeforeReset", {31'd0, pad_oe}, 1);
        checkValue("rxBeforeReset", rxQ.size() - rxMark, 1);
        #1 rst_n = 1'b0;
        #1;
        checkValue("oeAsyncReset", {31'd0, pad_oe}, 0);
        checkValue("padAsyncReset", {31'd0, pad_o}, 1);
        checkValue("busyAsyncReset", {31'd0, busy}, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        lastRx = '0;
        txMark = txBits.size();
        repeat (3) @(negedge clk);
        checkValue("rspReadyPostReset", {31'd0, rsp_ready}, 1);
        checkValue("rxDataPostReset", {24'd0, rx_data}, {24'd0, lastRx});
        checkValue("busyPostReset", {31'd0, busy}, 0);
        repeat (FRAME + 10) @(posedge clk);
        @(negedge clk);
        checkValue("noTxAfterReset", txBits.size() - txMark, 0);

        runExchange(8'h96, 1'b1, 8'($urandom));
        checkValue("noOverlap", overlaps, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
